// File: rtl/slot_pkg.sv
// Shared definitions for the slot grid engine: FSM encoding, line geometry
// and saturating arithmetic.
package slot_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SPIN   = 3'd1,
      EVAL   = 3'd2,
      COMMIT = 3'd3,
      PAYOUT = 3'd4
   } state_e;

   // Scored lines on an n x n grid: n rows, n columns, two diagonals.
   function automatic int num_lines(input int n);
      return 2 * n + 2;
   endfunction

   // Reel index (row-major) of element k on line l.
   function automatic int line_reel(input int n, input int l, input int k);
      if (l < n) begin
         return l * n + k;
      end else if (l < 2 * n) begin
         return k * n + (l - n);
      end else if (l == 2 * n) begin
         return k * n + k;
      end else begin
         return k * n + (n - 1 - k);
      end
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] lim);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, lim}) begin
         return lim;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/slot_reel.sv
// One reel: a modulo-NUM_SYM counter that steps up or down while running
// and holds whenever it is stopped.
module slot_reel #(
   parameter bit UP      = 1'b1,
   parameter int SYM_W   = 3,
   parameter int NUM_SYM = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run_i,
   input  logic             stop_i,
   output logic [SYM_W-1:0] sym_o
);

   localparam logic [SYM_W-1:0] SYM_TOP = SYM_W'(NUM_SYM - 1);
   localparam logic [SYM_W-1:0] SYM_RST = UP ? '0 : SYM_TOP;

   logic [SYM_W-1:0] sym_q, sym_d;

   always_comb begin
      sym_d = sym_q;
      if (run_i && !stop_i) begin
         if (UP) begin
            sym_d = (sym_q == SYM_TOP) ? '0 : sym_q + SYM_W'(1);
         end else begin
            sym_d = (sym_q == '0) ? SYM_TOP : sym_q - SYM_W'(1);
         end
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         sym_q <= SYM_RST;
      end else begin
         sym_q <= sym_d;
      end
   end

   assign sym_o = sym_q;

endmodule

// File: rtl/slot_grid_engine.sv
// N x N slot machine: credit accounting, reel spin/stop, sequential line
// scoring with jackpot, and serial coin payout. Define SLOT_AUTO_STOP_EN to
// force all reels to stop after AUTO_STOP_CYC spin cycles.
module slot_grid_engine
   import slot_pkg::*;
#(
   parameter int N             = 3,
   parameter int SYM_W         = 3,
   parameter int NUM_SYM       = 5,
   parameter int CREDIT_W      = 8,
   parameter int MAX_CREDIT    = 255,
   parameter int JACKPOT       = 99,
   parameter int AUTO_STOP_CYC = 64
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  coin_in,
   input  logic                  start,
   input  logic                  cash_req,
   input  logic [N*N-1:0]        btn,
   output logic [N*N*SYM_W-1:0]  slot,
   output logic [CREDIT_W-1:0]   credit,
   output logic [CREDIT_W-1:0]   win,
   output logic                  coin_out,
   output logic                  coin_reject,
   output logic                  busy
);

   localparam int R         = N * N;
   localparam int NUM_LINES = num_lines(N);
   localparam int LIDX_W    = $clog2(NUM_LINES + 1);

   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] WIN_MAX    = {CREDIT_W{1'b1}};
   localparam logic [31:0]         JACK_BONUS = 32'(JACKPOT);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] win_q, win_d;
   logic                coin_out_q, coin_out_d;
   logic                reject_q, reject_d;
   logic                busy_q, busy_d;
   logic [R-1:0]        stopped_q, stopped_d;
   logic [LIDX_W-1:0]   line_idx_q, line_idx_d;
   logic                pay_phase_q, pay_phase_d;

   logic [SYM_W-1:0]    sym [R];
   logic [R-1:0]        freeze;
   logic                run;
   logic                auto_stop;
   logic                start_ok;
   logic                coin_ok;
   logic [SYM_W-1:0]    line_sym;
   logic                line_eq;
   logic                all_eq;

`ifdef SLOT_AUTO_STOP_EN
   localparam int CNT_W = (AUTO_STOP_CYC > 1) ? $clog2(AUTO_STOP_CYC) : 1;
   logic [CNT_W-1:0] spin_cnt_q, spin_cnt_d;
   assign auto_stop = (state_q == SPIN) && (spin_cnt_q == CNT_W'(AUTO_STOP_CYC - 1));
`else
   assign auto_stop = 1'b0;
`endif

   assign run    = (state_q == SPIN);
   assign freeze = stopped_q | btn | {R{auto_stop}};

   for (genvar i = 0; i < R; i++) begin : g_reel
      slot_reel #(
         .UP      ((i % 2) == 0),
         .SYM_W   (SYM_W),
         .NUM_SYM (NUM_SYM)
      ) u_reel (
         .clk    (clk),
         .clr    (clr),
         .run_i  (run),
         .stop_i (freeze[i]),
         .sym_o  (sym[i])
      );
      assign slot[i*SYM_W +: SYM_W] = sym[i];
   end

   // A coin arriving together with an accepted start is consumed by it,
   // so it is never refused even at the credit ceiling.
   assign start_ok = start && (credit_q != '0);
   assign coin_ok  = coin_in && ((credit_q != CREDIT_MAX) || start_ok);

   always_comb begin
      line_sym = '0;
      line_eq  = 1'b1;
      all_eq   = 1'b1;
      for (int r = 0; r < R; r++) begin
         if (r == line_reel(N, int'(line_idx_q), 0)) begin
            line_sym = sym[r];
         end
      end
      for (int k = 1; k < N; k++) begin
         for (int r = 0; r < R; r++) begin
            if ((r == line_reel(N, int'(line_idx_q), k)) && (sym[r] != line_sym)) begin
               line_eq = 1'b0;
            end
         end
      end
      for (int r = 1; r < R; r++) begin
         if (sym[r] != sym[0]) begin
            all_eq = 1'b0;
         end
      end
   end

   // NOTE: every _d gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      win_d       = win_q;
      coin_out_d  = 1'b0;
      reject_d    = 1'b0;
      stopped_d   = stopped_q;
      line_idx_d  = line_idx_q;
      pay_phase_d = pay_phase_q;
`ifdef SLOT_AUTO_STOP_EN
      spin_cnt_d  = spin_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            reject_d = coin_in && !coin_ok;
            if (start_ok) begin
               if (!coin_in) begin
                  credit_d = credit_q - CREDIT_W'(1);
               end
               stopped_d = '0;
               state_d   = SPIN;
`ifdef SLOT_AUTO_STOP_EN
               spin_cnt_d = '0;
`endif
            end else begin
               if (coin_ok) begin
                  credit_d = credit_q + CREDIT_W'(1);
               end
               if (cash_req && (credit_q != '0)) begin
                  pay_phase_d = 1'b0;
                  state_d     = PAYOUT;
               end
            end
         end

         SPIN: begin
            reject_d  = coin_in;
            stopped_d = freeze;
`ifdef SLOT_AUTO_STOP_EN
            spin_cnt_d = spin_cnt_q + CNT_W'(1);
`endif
            if (&freeze) begin
               win_d      = '0;
               line_idx_d = '0;
               state_d    = EVAL;
            end
         end

         EVAL: begin
            reject_d = coin_in;
            if (line_idx_q < LIDX_W'(NUM_LINES)) begin
               if (line_eq) begin
                  win_d = CREDIT_W'(sat_add(32'(win_q), 32'(line_sym), 32'(WIN_MAX)));
               end
               line_idx_d = line_idx_q + LIDX_W'(1);
            end else begin
               if (all_eq) begin
                  win_d = CREDIT_W'(sat_add(32'(win_q), JACK_BONUS, 32'(WIN_MAX)));
               end
               state_d = COMMIT;
            end
         end

         COMMIT: begin
            reject_d = coin_in;
            credit_d = CREDIT_W'(sat_add(32'(credit_q), 32'(win_q), 32'(CREDIT_MAX)));
            state_d  = IDLE;
         end

         PAYOUT: begin
            reject_d = coin_in;
            if (!pay_phase_q) begin
               coin_out_d  = 1'b1;
               credit_d    = credit_q - CREDIT_W'(1);
               pay_phase_d = 1'b1;
            end else begin
               pay_phase_d = 1'b0;
               if (credit_q == '0) begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         credit_q    <= '0;
         win_q       <= '0;
         coin_out_q  <= 1'b0;
         reject_q    <= 1'b0;
         busy_q      <= 1'b0;
         stopped_q   <= '0;
         line_idx_q  <= '0;
         pay_phase_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         win_q       <= win_d;
         coin_out_q  <= coin_out_d;
         reject_q    <= reject_d;
         busy_q      <= busy_d;
         stopped_q   <= stopped_d;
         line_idx_q  <= line_idx_d;
         pay_phase_q <= pay_phase_d;
      end
   end

`ifdef SLOT_AUTO_STOP_EN
   always_ff @(posedge clk) begin
      if (clr) begin
         spin_cnt_q <= '0;
      end else begin
         spin_cnt_q <= spin_cnt_d;
      end
   end
`endif

   assign credit      = credit_q;
   assign win         = win_q;
   assign coin_out    = coin_out_q;
   assign coin_reject = reject_q;
   assign busy        = busy_q;

endmodule
